// File: rtl/id_ex_stage_buf_pkg.sv
// Shared definitions for the ID/EX stage: default field widths, the decoded
// bundle layout and the buffer occupancy encoding.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ALUCTL_W = 5;
  localparam int WB_SEL_W = 2;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     br_target;
    logic [REG_AW-1:0]   rd;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic [WB_SEL_W-1:0] wb_sel;
    logic                mem_write;
    logic                alu_src;
    logic                reg_write;
  } idex_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/id_ex_stage_buf_skid_buf2.sv
// Two-entry skid buffer over an opaque bundle: the main entry drives the
// outputs, the skid entry absorbs one beat so in_ready can be a flop.
module skid_buf2
  import core_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         acc, emt;

  assign out_valid_o = (occ_q != EMPTY);
  assign in_ready_o  = rdy_q;
  assign out_data_o  = main_q;

  assign acc = in_valid_i & rdy_q;
  assign emt = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      // Outputs keep the old bundle contents; only occupancy is dropped.
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (acc) begin
            main_d = in_data_i;
            occ_d  = ONE;
          end
        end
        ONE: begin
          if (acc && emt) begin
            main_d = in_data_i;
          end else if (acc) begin
            skid_d = in_data_i;
            occ_d  = FULL;
          end else if (emt) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (emt) begin
            main_d = skid_q;
            occ_d  = ONE;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
    rdy_d = (occ_d != FULL);
  end

endmodule

// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline stage: packs the decoded bundle with its precomputed branch
// target into a skid buffer, masks side-effect bits on bubbles, counts bubbles.
module id_ex_stage_buf
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int REG_AW   = core_pkg::REG_AW,
  parameter int ALUCTL_W = core_pkg::ALUCTL_W,
  parameter int WB_SEL_W = core_pkg::WB_SEL_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_rd1,
  input  logic [XLEN-1:0]     in_rd2,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic [ALUCTL_W-1:0] in_alu_ctl,
  input  logic [WB_SEL_W-1:0] in_wb_sel,
  input  logic                in_mem_write,
  input  logic                in_alu_src,
  input  logic                in_reg_write,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_rd1,
  output logic [XLEN-1:0]     out_rd2,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_br_target,
  output logic [REG_AW-1:0]   out_rd,
  output logic [ALUCTL_W-1:0] out_alu_ctl,
  output logic [WB_SEL_W-1:0] out_wb_sel,
  output logic                out_mem_write,
  output logic                out_alu_src,
  output logic                out_reg_write,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam int BW = 5 * XLEN + REG_AW + ALUCTL_W + WB_SEL_W + 3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  logic [XLEN-1:0]  br_tgt;
  logic [BW-1:0]    in_bus, out_bus;
  logic             mw_raw, rw_raw;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Carry out of the target add is intentionally dropped (mod 2^XLEN).
  assign br_tgt = in_pc + in_imm;

  assign in_bus = {in_pc, in_rd1, in_rd2, in_imm, br_tgt, in_rd, in_alu_ctl,
                   in_wb_sel, in_mem_write, in_alu_src, in_reg_write};

  skid_buf2 #(.W(BW)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_bus),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_bus)
  );

  assign {out_pc, out_rd1, out_rd2, out_imm, out_br_target, out_rd, out_alu_ctl,
          out_wb_sel, mw_raw, out_alu_src, rw_raw} = out_bus;

  assign out_mem_write = mw_raw & out_valid;
  assign out_reg_write = rw_raw & out_valid;

  assign cnt_d      = (out_ready && !out_valid) ? sat_inc(cnt_q) : cnt_q;
  assign bubble_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed bench for id_ex_stage_buf: reset, streaming, wrap, backpressure,
// flush, mid-transfer reset and bubble counter saturation (CNT_W=4).
module tb_id_ex_stage_buf;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rd, in_alu_ctl;
  logic [1:0]  in_wb_sel;
  logic        in_mem_write, in_alu_src, in_reg_write;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rd1, out_rd2, out_imm, out_br_target;
  logic [4:0]  out_rd, out_alu_ctl;
  logic [1:0]  out_wb_sel;
  logic        out_mem_write, out_alu_src, out_reg_write;
  logic [3:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_buf #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rd(in_rd), .in_alu_ctl(in_alu_ctl), .in_wb_sel(in_wb_sel),
    .in_mem_write(in_mem_write), .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_br_target(out_br_target), .out_rd(out_rd), .out_alu_ctl(out_alu_ctl),
    .out_wb_sel(out_wb_sel), .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
    .out_reg_write(out_reg_write), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        fl, iv, ordy;
    logic [31:0] pc, imm;
    logic [4:0]  rd;
    logic        rw, mw;
    logic        ev, er;
    logic [31:0] epc, eimm, ebr;
    logic [4:0]  erd;
    logic        erw, emw;
    int          ebub;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  // Operand and minor fields are derived from pc/rd so expectations follow.
  task automatic drive(input logic fl, input logic iv, input logic ordy,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rw, input logic mw);
    flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_imm = imm; in_rd = rd;
    in_rd1 = pc ^ 32'hA5A5A5A5; in_rd2 = ~pc;
    in_alu_ctl = pc[16:12] ^ rd; in_wb_sel = rd[1:0]; in_alu_src = rd[0];
    in_reg_write = rw; in_mem_write = mw;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
      input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
      input logic rw, input logic mw, input logic ev, input logic er,
      input logic [31:0] epc, input logic [31:0] eimm, input logic [31:0] ebr,
      input logic [4:0] erd, input logic erw, input logic emw, input int ebub);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.imm = imm; v.rd = rd;
    v.rw = rw; v.mw = mw; v.ev = ev; v.er = er; v.epc = epc; v.eimm = eimm;
    v.ebr = ebr; v.erd = erd; v.erw = erw; v.emw = emw; v.ebub = ebub;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset asserted with a live input and EX ready.
    rst = 1'b1;
    drive(0, 1, 1, 32'h100, 32'h20, 5'd1, 1, 1);
    #1;
    chk("rst_out_valid", 0, {31'd0, out_valid}, 0);
    chk("rst_in_ready", 0, {31'd0, in_ready}, 1);
    step();
    chk("rst_out_pc", 0, out_pc, 0);
    chk("rst_br_target", 0, out_br_target, 0);
    chk("rst_rd1", 0, out_rd1, 0);
    chk("rst_rw", 0, {31'd0, out_reg_write}, 0);
    chk("rst_bubble", 0, {28'd0, bubble_cnt}, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          fl iv or pc            imm           rd rw mw  ev er epc           eimm          ebr           erd rw mw bub
    tbl[0]  = mk(0, 1, 0, 32'h100,      32'h20,       1, 1, 0,  1, 1, 32'h100,      32'h20,       32'h120,      1, 1, 0, 0);
    tbl[1]  = mk(0, 1, 1, 32'h200,      32'hFFFFFFF0, 2, 1, 1,  1, 1, 32'h200,      32'hFFFFFFF0, 32'h1F0,      2, 1, 1, 0);
    tbl[2]  = mk(0, 0, 1, 0,            0,            0, 0, 0,  0, 1, 32'h200,      32'hFFFFFFF0, 32'h1F0,      2, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0,            0,            0, 0, 0,  0, 1, 32'h200,      32'hFFFFFFF0, 32'h1F0,      2, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 32'hFFFFFFF0, 32'h20,       3, 0, 1,  1, 1, 32'hFFFFFFF0, 32'h20,       32'h10,       3, 0, 1, 1);
    tbl[5]  = mk(0, 0, 1, 0,            0,            0, 0, 0,  0, 1, 32'hFFFFFFF0, 32'h20,       32'h10,       3, 0, 0, 1);
    tbl[6]  = mk(0, 1, 0, 32'h1000,     32'h4,        4, 1, 0,  1, 1, 32'h1000,     32'h4,        32'h1004,     4, 1, 0, 1);
    tbl[7]  = mk(0, 1, 0, 32'h2000,     32'h8,        5, 0, 1,  1, 0, 32'h1000,     32'h4,        32'h1004,     4, 1, 0, 1);
    tbl[8]  = mk(0, 1, 0, 32'h3000,     32'hC,        6, 1, 1,  1, 0, 32'h1000,     32'h4,        32'h1004,     4, 1, 0, 1);
    tbl[9]  = mk(0, 1, 0, 32'h3000,     32'hC,        6, 1, 1,  1, 0, 32'h1000,     32'h4,        32'h1004,     4, 1, 0, 1);
    tbl[10] = mk(0, 1, 1, 32'h3000,     32'hC,        6, 1, 1,  1, 1, 32'h2000,     32'h8,        32'h2008,     5, 0, 1, 1);
    tbl[11] = mk(0, 1, 1, 32'h3000,     32'hC,        6, 1, 1,  1, 1, 32'h3000,     32'hC,        32'h300C,     6, 1, 1, 1);
    tbl[12] = mk(0, 0, 1, 0,            0,            0, 0, 0,  0, 1, 32'h3000,     32'hC,        32'h300C,     6, 0, 0, 1);
    tbl[13] = mk(0, 1, 0, 32'h4000,     32'h10,       7, 1, 1,  1, 1, 32'h4000,     32'h10,       32'h4010,     7, 1, 1, 1);
    tbl[14] = mk(0, 1, 0, 32'h5000,     32'h0,        8, 1, 1,  1, 0, 32'h4000,     32'h10,       32'h4010,     7, 1, 1, 1);
    tbl[15] = mk(1, 1, 0, 32'h6000,     32'h0,        9, 1, 1,  0, 1, 32'h4000,     32'h10,       32'h4010,     7, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0,            0,            0, 0, 0,  0, 1, 32'h4000,     32'h10,       32'h4010,     7, 0, 0, 1);
    tbl[17] = mk(1, 1, 0, 32'h6000,     32'h0,        9, 1, 1,  0, 1, 32'h4000,     32'h10,       32'h4010,     7, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 0,            0,            0, 0, 0,  0, 1, 32'h4000,     32'h10,       32'h4010,     7, 0, 0, 1);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].pc, tbl[i].imm, tbl[i].rd,
            tbl[i].rw, tbl[i].mw);
      step();
      chk("out_valid", i, {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk("in_ready", i, {31'd0, in_ready}, {31'd0, tbl[i].er});
      chk("out_pc", i, out_pc, tbl[i].epc);
      chk("out_imm", i, out_imm, tbl[i].eimm);
      chk("out_br_target", i, out_br_target, tbl[i].ebr);
      chk("out_rd1", i, out_rd1, tbl[i].epc ^ 32'hA5A5A5A5);
      chk("out_rd2", i, out_rd2, ~tbl[i].epc);
      chk("out_rd", i, {27'd0, out_rd}, {27'd0, tbl[i].erd});
      chk("out_alu_ctl", i, {27'd0, out_alu_ctl}, {27'd0, tbl[i].epc[16:12] ^ tbl[i].erd});
      chk("out_wb_sel", i, {30'd0, out_wb_sel}, {30'd0, tbl[i].erd[1:0]});
      chk("out_alu_src", i, {31'd0, out_alu_src}, {31'd0, tbl[i].erd[0]});
      chk("out_reg_write", i, {31'd0, out_reg_write}, {31'd0, tbl[i].erw});
      chk("out_mem_write", i, {31'd0, out_mem_write}, {31'd0, tbl[i].emw});
      chk("bubble_cnt", i, {28'd0, bubble_cnt}, tbl[i].ebub);
    end

    // Reset while the buffer is full discards both entries.
    drive(0, 1, 0, 32'h7000, 32'h4, 5'd10, 1, 1);
    step();
    drive(0, 1, 0, 32'h8000, 32'h4, 5'd11, 1, 1);
    step();
    chk("full_before_rst", 100, {31'd0, in_ready}, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 100, {31'd0, out_valid}, 0);
    chk("midrst_in_ready", 100, {31'd0, in_ready}, 1);
    chk("midrst_out_pc", 100, out_pc, 0);
    chk("midrst_bubble", 100, {28'd0, bubble_cnt}, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("post_rst_empty", 101, {31'd0, out_valid}, 0);

    // Bubble counter saturation: one bubble already counted above.
    for (int i = 2; i <= 20; i++) begin
      step();
      if (i == 5) chk("bubble_5", 102, {28'd0, bubble_cnt}, 5);
      if (i == 15) chk("bubble_15", 102, {28'd0, bubble_cnt}, 15);
    end
    chk("bubble_sat", 102, {28'd0, bubble_cnt}, 15);
    step();
    chk("bubble_stay", 102, {28'd0, bubble_cnt}, 15);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("bubble_flush_keep", 102, {28'd0, bubble_cnt}, 15);
    do_reset();
    chk("bubble_after_rst", 103, {28'd0, bubble_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
